// File: rtl/thread_fetch_scheduler.sv
// Fetch-side scheduler for a 4-thread fine-grained multithreaded pipeline.
// Keeps one PC per hardware thread, picks one eligible thread per cycle in
// round-robin order and drives its PC and thread ID, registered, into IF/ID.
// Handles hazard stalls, per-thread redirects, halts and enables.

module thread_fetch_scheduler #(
    parameter int INSTMEM_LOG2_DEEP = 8
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [3:0]                   thread_en,
    input  logic                         hazard,
    input  logic                         redirect_valid,
    input  logic [1:0]                   redirect_tid,
    input  logic [INSTMEM_LOG2_DEEP-1:0] redirect_pc,
    input  logic                         halt_valid,
    input  logic [1:0]                   halt_tid,
    output logic [INSTMEM_LOG2_DEEP-1:0] PC_out,
    output logic [1:0]                   thread_id_out,
    output logic                         fetch_valid,
    output logic [3:0]                   thread_active
);

    localparam int W = INSTMEM_LOG2_DEEP;

    // Each thread starts in its own quarter of instruction memory.
    function automatic logic [W-1:0] base_pc(input logic [1:0] tid);
        logic [W-1:0] b;
        b = {W{1'b0}};
        b[W-1 -: 2] = tid;
        return b;
    endfunction

    logic [W-1:0] pc_r [4];
    logic [3:0]   halted_r;
    logic [1:0]   last_tid_r;
    logic [W-1:0] pc_out_r;
    logic [1:0]   tid_out_r;
    logic         fetch_valid_r;

    logic [3:0]   elig_s;
    logic         any_elig_s;
    logic [1:0]   sel_s;
    logic         issue_s;

    assign elig_s        = thread_en & ~halted_r;
    assign thread_active = elig_s;
    assign issue_s       = ~hazard & any_elig_s;

    assign PC_out        = pc_out_r;
    assign thread_id_out = tid_out_r;
    assign fetch_valid   = fetch_valid_r;

    // Round-robin pick: first eligible thread after the last one granted,
    // wrapping back to the last granted thread itself as lowest priority.
    always_comb begin
        sel_s      = 2'd0;
        any_elig_s = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (!any_elig_s && elig_s[last_tid_r + i[1:0]]) begin
                sel_s      = last_tid_r + i[1:0];
                any_elig_s = 1'b1;
            end else begin
                sel_s      = sel_s;
                any_elig_s = any_elig_s;
            end
        end
    end

    // Per-thread PC/halt state, round-robin pointer and the registered fetch outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int t = 0; t < 4; t++) begin
                pc_r[t] <= base_pc(2'(t));
            end
            halted_r      <= 4'b0000;
            last_tid_r    <= 2'd3;
            pc_out_r      <= {W{1'b0}};
            tid_out_r     <= 2'd0;
            fetch_valid_r <= 1'b0;
        end else begin
            for (int t = 0; t < 4; t++) begin
                if (!thread_en[t]) begin
                    // A parked thread is held at its base so re-enabling restarts it.
                    pc_r[t]     <= base_pc(2'(t));
                    halted_r[t] <= 1'b0;
                end else begin
                    // A redirect wins over the post-issue increment.
                    if (redirect_valid && (redirect_tid == 2'(t))) begin
                        pc_r[t] <= redirect_pc;
                    end else if (issue_s && (sel_s == 2'(t))) begin
                        pc_r[t] <= pc_r[t] + {{(W-1){1'b0}}, 1'b1};
                    end else begin
                        pc_r[t] <= pc_r[t];
                    end
                    if (halt_valid && (halt_tid == 2'(t))) begin
                        halted_r[t] <= 1'b1;
                    end else begin
                        halted_r[t] <= halted_r[t];
                    end
                end
            end

            // A stall freezes the fetch outputs and the round-robin pointer.
            if (!hazard) begin
                if (any_elig_s) begin
                    pc_out_r      <= pc_r[sel_s];
                    tid_out_r     <= sel_s;
                    fetch_valid_r <= 1'b1;
                    last_tid_r    <= sel_s;
                end else begin
                    pc_out_r      <= pc_out_r;
                    tid_out_r     <= tid_out_r;
                    fetch_valid_r <= 1'b0;
                    last_tid_r    <= last_tid_r;
                end
            end else begin
                pc_out_r      <= pc_out_r;
                tid_out_r     <= tid_out_r;
                fetch_valid_r <= fetch_valid_r;
                last_tid_r    <= last_tid_r;
            end
        end
    end

endmodule

// File: tb/tb_thread_fetch_scheduler.sv
// Scoreboard bench for thread_fetch_scheduler: a driver applies directed and
// random stimulus and pushes the reference model's expected outputs into a
// queue; an independent monitor pops and compares after every rising edge.

module tb_thread_fetch_scheduler;

    localparam int W = 8;

    logic         CLK;
    logic         RST;
    logic [3:0]   thread_en;
    logic         hazard;
    logic         redirect_valid;
    logic [1:0]   redirect_tid;
    logic [W-1:0] redirect_pc;
    logic         halt_valid;
    logic [1:0]   halt_tid;
    logic [W-1:0] PC_out;
    logic [1:0]   thread_id_out;
    logic         fetch_valid;
    logic [3:0]   thread_active;

    thread_fetch_scheduler #(.INSTMEM_LOG2_DEEP(W)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .thread_en      (thread_en),
        .hazard         (hazard),
        .redirect_valid (redirect_valid),
        .redirect_tid   (redirect_tid),
        .redirect_pc    (redirect_pc),
        .halt_valid     (halt_valid),
        .halt_tid       (halt_tid),
        .PC_out         (PC_out),
        .thread_id_out  (thread_id_out),
        .fetch_valid    (fetch_valid),
        .thread_active  (thread_active)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [7:0] pc;
        logic [1:0] tid;
        logic       fv;
        logic [3:0] act;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state: plain per-thread arrays and integers.
    int   pcm [4];
    bit   hm  [4];
    int   lastm;
    int   mpc;
    int   mtid;
    bit   mfv;

    function automatic void model_reset();
        for (int t = 0; t < 4; t++) begin
            pcm[t] = t * 64;
            hm[t]  = 1'b0;
        end
        lastm = 3;
        mpc   = 0;
        mtid  = 0;
        mfv   = 1'b0;
    endfunction

    function automatic exp_t model_record(input logic [3:0] en);
        exp_t e;
        e.pc  = mpc[7:0];
        e.tid = mtid[1:0];
        e.fv  = mfv;
        for (int t = 0; t < 4; t++) e.act[t] = en[t] && !hm[t];
        return e;
    endfunction

    // One rising edge of the model with the given inputs.
    function automatic void model_clock(input logic [3:0] en, input logic hz,
                                        input logic rv, input logic [1:0] rt,
                                        input logic [7:0] rp, input logic hv,
                                        input logic [1:0] ht);
        int sel;
        sel = -1;
        for (int k = 1; k <= 4; k++) begin
            int t;
            t = (lastm + k) % 4;
            if (sel < 0 && en[t] && !hm[t]) sel = t;
        end
        if (!hz) begin
            if (sel >= 0) begin
                mpc   = pcm[sel];
                mtid  = sel;
                mfv   = 1'b1;
                lastm = sel;
            end else begin
                mfv = 1'b0;
            end
        end
        for (int t = 0; t < 4; t++) begin
            if (!en[t]) begin
                pcm[t] = t * 64;
                hm[t]  = 1'b0;
            end else begin
                if (rv && rt == t) pcm[t] = rp;
                else if (!hz && sel == t) pcm[t] = (pcm[t] + 1) % 256;
                if (hv && ht == t) hm[t] = 1'b1;
            end
        end
    endfunction

    // rst_mode: 0 = run, 1 = reset held low all cycle, 2 = reset dropped mid-cycle.
    task automatic step(input logic [3:0] en, input logic hz,
                        input logic rv, input logic [1:0] rt, input logic [7:0] rp,
                        input logic hv, input logic [1:0] ht, input int rst_mode);
        @(negedge CLK);
        thread_en      = en;
        hazard         = hz;
        redirect_valid = rv;
        redirect_tid   = rt;
        redirect_pc    = rp;
        halt_valid     = hv;
        halt_tid       = ht;
        if (rst_mode == 1) begin
            RST = 1'b0;
            model_reset();
        end else if (rst_mode == 2) begin
            RST = 1'b1;
            #2;
            RST = 1'b0;
            #1;
            total++;
            if (PC_out !== 8'h00 || thread_id_out !== 2'd0 || fetch_valid !== 1'b0) begin
                bad++;
                $display("FAIL async_reset: got pc=%h tid=%0d fv=%b, want pc=00 tid=0 fv=0",
                         PC_out, thread_id_out, fetch_valid);
            end
            model_reset();
        end else begin
            RST = 1'b1;
            model_clock(en, hz, rv, rt, rp, hv, ht);
        end
        exp_q.push_back(model_record(en));
    endtask

    task automatic run(input logic [3:0] en, input int n);
        for (int i = 0; i < n; i++) step(en, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 0);
    endtask

    // Monitor: compare the DUT against the next expected record after each edge.
    always @(posedge CLK) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if (PC_out !== e.pc || thread_id_out !== e.tid ||
                fetch_valid !== e.fv || thread_active !== e.act) begin
                bad++;
                $display("FAIL fetch_out @%0t: got pc=%h tid=%0d fv=%b act=%b, want pc=%h tid=%0d fv=%b act=%b",
                         $time, PC_out, thread_id_out, fetch_valid, thread_active,
                         e.pc, e.tid, e.fv, e.act);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        RST            = 1'b0;
        thread_en      = 4'hF;
        hazard         = 1'b0;
        redirect_valid = 1'b0;
        redirect_tid   = 2'd0;
        redirect_pc    = 8'h00;
        halt_valid     = 1'b0;
        halt_tid       = 2'd0;
        model_reset();

        // Full rotation from reset.
        step(4'hF, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1);
        step(4'hF, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1);
        run(4'hF, 8);

        // Threads 0 and 2 only.
        step(4'b0101, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1);
        run(4'b0101, 4);

        // Hazard freeze after tid1 issues 0x40.
        step(4'hF, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1);
        run(4'hF, 2);
        for (int i = 0; i < 3; i++) step(4'hF, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 0);
        run(4'hF, 2);

        // Redirect tid1 to 0x55 in the cycle it issues 0x41.
        step(4'hF, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1);
        run(4'hF, 5);
        step(4'hF, 1'b0, 1'b1, 2'd1, 8'h55, 1'b0, 2'd0, 0);
        run(4'hF, 6);
        // Redirect tid3 to 0xFF, then watch it wrap.
        step(4'hF, 1'b0, 1'b1, 2'd3, 8'hFF, 1'b0, 2'd0, 0);
        run(4'hF, 9);
        // Redirect to a disabled thread is ignored.
        step(4'b1110, 1'b0, 1'b1, 2'd0, 8'h33, 1'b0, 2'd0, 0);
        run(4'hF, 4);

        // Halt tid2, then pulse its enable to restart it at base.
        step(4'hF, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 0);
        run(4'hF, 6);
        step(4'b1011, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 0);
        run(4'hF, 6);
        // Halt plus redirect on the same thread in one cycle.
        step(4'hF, 1'b0, 1'b1, 2'd1, 8'hA0, 1'b1, 2'd1, 0);
        run(4'hF, 4);
        step(4'b1101, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 0);
        run(4'hF, 4);

        // All threads parked: fetch_valid drops, PC holds.
        run(4'h0, 3);
        run(4'hF, 3);

        // Asynchronous reset in the middle of a cycle, then restart.
        step(4'hF, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2);
        run(4'hF, 4);

        // Randomised traffic.
        for (int i = 0; i < 800; i++) begin
            logic [3:0] en;
            en = ($urandom_range(0, 9) < 7) ? 4'hF : 4'($urandom_range(0, 15));
            step(en,
                 ($urandom_range(0, 9) < 2),
                 ($urandom_range(0, 9) < 2), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 9) < 1), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 199) == 0) ? 1 : 0);
        end

        repeat (2) @(posedge CLK);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d records left, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/thread_fetch_scheduler.md
Name: thread_fetch_scheduler

Overview:
- Fetch-side scheduler for the 4-thread fine-grained multithreaded pipeline.
- Holds one PC per hardware thread and picks one eligible thread per cycle, round-robin.
- Drives the selected PC and thread ID, registered, into the IF/ID stage register.
- Honours hazard stalls, per-thread branch redirects, per-thread halt and per-thread enable.

Parameters:
- INSTMEM_LOG2_DEEP, 8, instruction-memory address width (PC width W).
- Thread count is fixed at 4 (2-bit thread ID); it is not a parameter.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  asynchronous, active-low reset.
- thread_en  in  4  per-thread enable; bit t low parks thread t.
- hazard  in  1  pipeline stall; freezes selection and outputs.
- redirect_valid  in  1  load a new PC into one thread.
- redirect_tid  in  2  thread ID for the redirect.
- redirect_pc  in  W  new PC for the redirect.
- halt_valid  in  1  halt one thread.
- halt_tid  in  2  thread ID for the halt.
- PC_out  out  W  fetch PC of the selected thread.
- thread_id_out  out  2  ID of the selected thread.
- fetch_valid  out  1  PC_out/thread_id_out carry a real fetch this cycle.
- thread_active  out  4  per-thread eligible flags (thread_en & ~halted), combinational from state.

Behaviour:
- State: pc[0..3] (W bits each), halted[3:0], last_tid[1:0], plus the registered outputs.
- Base PC: base(t) = t << (W-2). With W=8 the bases are 0x00, 0x40, 0x80, 0xC0.
- Reset (RST=0, asynchronous, takes effect mid-operation too):
  - pc[t] = base(t); halted = 0; last_tid = 3, so thread 0 is granted first.
  - PC_out = 0, thread_id_out = 0, fetch_valid = 0.
- Eligibility: elig[t] = thread_en[t] & ~halted[t], using registered halted (pre-edge values).
- Selection: first eligible thread searching last_tid+1, last_tid+2, last_tid+3, last_tid, all mod 4.
- Cycle with hazard=0 and some thread eligible (sel = selected thread):
  - PC_out <= pc[sel]; thread_id_out <= sel; fetch_valid <= 1.
  - pc[sel] <= pc[sel] + 1, wrapping mod 2^W.
  - last_tid <= sel.
- Cycle with hazard=0 and no thread eligible:
  - fetch_valid <= 0; PC_out, thread_id_out, pc[] and last_tid hold.
- Cycle with hazard=1:
  - PC_out, thread_id_out, fetch_valid, last_tid hold; no increment.
  - Redirect, halt and enable updates still apply to internal state.
- Latency: selection is registered; one cycle from a state or input change to PC_out.
- Redirect: redirect_valid=1 writes pc[redirect_tid] <= redirect_pc.
  - Beats the increment when the same thread is selected that cycle; the issued PC is still the old pc[sel].
  - Flushing the already-issued instruction is downstream's job, not this block's.
- Halt: halt_valid=1 sets halted[halt_tid].
  - Affects selection from the next cycle; a thread selected in the halt cycle still issues.
  - Halt and redirect to the same thread in one cycle: both apply.
- Enable low: thread_en[t]=0 forces pc[t] <= base(t) and halted[t] <= 0 every cycle; halt_valid to that thread is ignored.
  - Re-raising thread_en[t] restarts thread t at base(t).
  - Redirect to a disabled thread is ignored.
- A thread whose enable drops while it is selected still issues in that cycle, then parks.

Test Plan:
- Reset, thread_en=4'hF, hazard=0 -> 8 cycles give tid 0,1,2,3,0,1,2,3 with PC 0x00,0x40,0x80,0xC0,0x01,0x41,0x81,0xC1; fetch_valid=1 throughout.
- thread_en=4'b0101 from reset -> tid 0,2,0,2 with PC 0x00,0x80,0x01,0x81; thread_active=4'b0101.
- hazard=1 for 3 cycles after tid1/PC 0x40 issues -> outputs frozen at 0x40/1; on release, next issue is tid2/PC 0x80 with no PC skipped.
- redirect tid1 to 0x55 in the cycle tid1 issues 0x41 -> tid1's next issue is 0x55, then 0x56; other threads unaffected. Redirect tid3 to 0xFF -> tid3 issues 0xFF, then 0x00 (wrap).
- halt tid2 -> tid2 absent from the rotation from the next cycle, thread_active[2]=0. Pulse thread_en[2] low then high -> tid2 resumes at 0x80.
- thread_en=0 -> fetch_valid=0 with PC_out held. Assert RST low mid-stream (not on a clock edge) -> outputs immediately 0/0/0; after release, tid0 issues 0x00 first.
